// File: rtl/freq_meter_if.sv
// Bundles the frequency meter's control input, the measured signal and the
// result/status outputs. The measuring block takes the slave side; whoever
// drives enable and reads results takes the master side.
interface freq_meter_if #(
  parameter int RES_W = 16
);
  logic             en;
  logic             sig_in;
  logic [RES_W-1:0] freq_count;
  logic             freq_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output en,
    output sig_in,
    input  freq_count,
    input  freq_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  en,
    input  sig_in,
    output freq_count,
    output freq_valid,
    output overflow,
    output busy
  );
endinterface

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of an asynchronous input over a fixed
// gate window of GATE_CYCLES clk periods and publishes the count once per
// window. Windows run back to back while enabled; dropping enable mid-window
// discards the partial count and keeps the last published result.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | not measuring; counters held at zero, busy low
//   MEASURE | gate window running; edges counted, result published at end
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int GATE_W      = 27,
  parameter int RES_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  freq_meter_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [RES_W-1:0]  CNT_MAX   = '1;

  logic [0:0]        state;
  logic              s1, s2, s3;
  logic              sig_edge;
  logic [GATE_W-1:0] gate_cnt;
  logic [RES_W-1:0]  edge_cnt;
  logic              sat_flag;

  logic              cnt_at_max;
  logic [RES_W-1:0]  edge_next;
  logic              sat_next;
  logic              window_end;

  logic [RES_W-1:0]  freq_count;
  logic              freq_valid;
  logic              overflow;

  // Two-flop synchronizer for the asynchronous input plus a history flop,
  // so a rise shows up as a one-cycle pulse two cycles after it is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge = s2 & ~s3;

  // Edge count including this cycle's edge; saturates at the top value and
  // remembers that an increment was lost.
  always_comb begin
    cnt_at_max = (edge_cnt == CNT_MAX);
    edge_next  = edge_cnt;
    if (sig_edge && !cnt_at_max) begin
      edge_next = edge_cnt + 1'b1;
    end
    sat_next   = sat_flag | (sig_edge & cnt_at_max);
    window_end = (state == MEASURE) && (gate_cnt == GATE_LAST);
  end

  // Window sequencing. Window end wins over a dropped enable so the final
  // window is still published; a new window starts on the very next cycle
  // when enable stays high, so no edge falls between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
    end else if (state == IDLE) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
      if (bus.en) begin
        state <= MEASURE;
      end
    end else begin
      if (window_end) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat_flag <= 1'b0;
        state    <= bus.en ? MEASURE : IDLE;
      end else if (!bus.en) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat_flag <= 1'b0;
        state    <= IDLE;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_next;
        sat_flag <= sat_next;
      end
    end
  end

  // Result registers: loaded only at window end and held otherwise, with a
  // single-cycle valid pulse marking each update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_count <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= window_end;
      if (window_end) begin
        freq_count <= edge_next;
        overflow   <= sat_next;
      end
    end
  end

  assign bus.freq_count = freq_count;
  assign bus.freq_valid = freq_valid;
  assign bus.overflow   = overflow;
  assign bus.busy       = (state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter with a 20-cycle gate. Two instances share stimulus:
// one with a 4-bit result, one with a 3-bit result to exercise saturation.
module tb_freq_meter;

  localparam int GATE = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  freq_meter_if #(.RES_W(4)) bus4 ();
  freq_meter_if #(.RES_W(3)) bus3 ();

  freq_meter #(.GATE_CYCLES(GATE), .GATE_W(5), .RES_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  freq_meter #(.GATE_CYCLES(GATE), .GATE_W(5), .RES_W(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  logic en      = 1'b0;
  logic sig     = 1'b0;
  logic man_sig = 1'b0;
  int   period  = 0;   // >0 square wave, 0 held low, <0 follows man_sig
  int   phase   = 0;

  assign bus4.en     = en;
  assign bus3.en     = en;
  assign bus4.sig_in = sig;
  assign bus3.sig_in = sig;

  int checks = 0;
  int errors = 0;
  int dbl    = 0;

  typedef struct {
    int period;
    int cnt4;
    int ov4;
    int cnt3;
    int ov3;
  } vec_t;

  vec_t vecs[6];

  // Signal generator: updates sig 2 time units after each rising clk edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (period > 0) begin
        phase = (phase + 1 >= period) ? 0 : phase + 1;
        sig   = (phase < period / 2);
      end else if (period == 0) begin
        sig = 1'b0;
      end else begin
        sig = man_sig;
      end
    end
  end

  // Tracks back-to-back valid pulses on either instance.
  initial begin
    logic pv4, pv3;
    pv4 = 1'b0;
    pv3 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus4.freq_valid && pv4) dbl++;
      if (bus3.freq_valid && pv3) dbl++;
      pv4 = bus4.freq_valid;
      pv3 = bus3.freq_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advances until the 4-bit instance pulses valid; n = cycles waited,
  // busy_low = sampled cycles with busy low along the way.
  task automatic wait_valid(output int n, output int busy_low);
    n        = 0;
    busy_low = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!bus4.busy) busy_low++;
    end while (!bus4.freq_valid && n < 100);
    if (!bus4.freq_valid) begin
      check("valid_timeout", 0, 1);
    end else begin
      check("valid_align_res3", int'(bus3.freq_valid), 1);
    end
  endtask

  initial begin
    int n, b, bad, vcount;
    int r[4];

    vecs[0] = '{4,  5, 0, 5, 0};
    vecs[1] = '{2, 10, 0, 7, 1};
    vecs[2] = '{4,  5, 0, 5, 0};
    vecs[3] = '{5,  4, 0, 4, 0};
    vecs[4] = '{10, 2, 0, 2, 0};
    vecs[5] = '{0,  0, 0, 0, 0};

    // Reset values
    step(3);
    check("rst_count", int'(bus4.freq_count), 0);
    check("rst_valid", int'(bus4.freq_valid), 0);
    check("rst_overflow", int'(bus4.overflow), 0);
    check("rst_busy", int'(bus4.busy), 0);
    rst = 1'b0;

    // Publish a nonzero result, then reset mid-window
    en     = 1'b1;
    period = 4;
    wait_valid(n, b);
    wait_valid(n, b);
    check("pre_reset_count", int'(bus4.freq_count), 5);
    step(7);
    rst = 1'b1;
    #1;
    check("midrst_count", int'(bus4.freq_count), 0);
    check("midrst_busy", int'(bus4.busy), 0);
    check("midrst_valid", int'(bus4.freq_valid), 0);
    step(2);
    rst    = 1'b0;
    en     = 1'b0;
    period = 3;
    bad    = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus4.freq_valid || bus4.busy || bus4.overflow || bus4.freq_count != 0) bad++;
      if (bus3.freq_valid || bus3.busy || bus3.overflow || bus3.freq_count != 0) bad++;
    end
    check("idle_quiet_cycles_bad", bad, 0);

    // Table: steady square waves, first window after a change discarded
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      period = vecs[i].period;
      wait_valid(n, b);
      wait_valid(n, b);
      check($sformatf("v%0d_spacing", i), n, GATE);
      check($sformatf("v%0d_busy_low", i), b, 0);
      check($sformatf("v%0d_count4", i), int'(bus4.freq_count), vecs[i].cnt4);
      check($sformatf("v%0d_ovf4", i), int'(bus4.overflow), vecs[i].ov4);
      check($sformatf("v%0d_count3", i), int'(bus3.freq_count), vecs[i].cnt3);
      check($sformatf("v%0d_ovf3", i), int'(bus3.overflow), vecs[i].ov3);
    end

    // Abort at gate_cnt=10, re-enable 5 cycles later
    period = 5;
    wait_valid(n, b);
    wait_valid(n, b);
    check("abort_prior_count", int'(bus4.freq_count), 4);
    step(10);
    en     = 1'b0;
    period = 4;
    vcount = 0;
    bad    = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus4.freq_valid) vcount++;
      if (bus4.busy) bad++;
      if (bus4.freq_count != 4) bad++;
    end
    check("abort_valids", vcount, 0);
    check("abort_hold_bad", bad, 0);
    en = 1'b1;
    // en sampled on the next edge, 20-cycle window, result one cycle later
    wait_valid(n, b);
    check("reenable_latency", n, GATE + 1);
    check("reenable_count", int'(bus4.freq_count), 5);
    check("reenable_ovf", int'(bus4.overflow), 0);

    // Edge pulse in the last cycle of a window, then in the first
    period  = -1;
    man_sig = 1'b0;
    wait_valid(n, b);
    wait_valid(n, b);
    step(17);
    man_sig = 1'b1;
    step(1);
    man_sig = 1'b0;
    wait_valid(n, b);
    check("last_cycle_win_a", int'(bus4.freq_count), 1);
    wait_valid(n, b);
    check("last_cycle_win_b", int'(bus4.freq_count), 0);
    step(18);
    man_sig = 1'b1;
    step(1);
    man_sig = 1'b0;
    wait_valid(n, b);
    check("first_cycle_win_c", int'(bus4.freq_count), 0);
    wait_valid(n, b);
    check("first_cycle_win_d", int'(bus4.freq_count), 1);

    // Slow signal: one rise per two windows
    period = 40;
    wait_valid(n, b);
    for (int i = 0; i < 4; i++) begin
      wait_valid(n, b);
      r[i] = int'(bus4.freq_count);
    end
    check("slow_total", r[0] + r[1] + r[2] + r[3], 2);
    check("slow_alt_01", int'(r[0] != r[1]), 1);
    check("slow_alt_12", int'(r[1] != r[2]), 1);
    check("slow_alt_23", int'(r[2] != r[3]), 1);

    check("double_valid_pulses", dbl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external or slow-divided signal. It counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clk periods.
- Complements the team's divided-clock counters: those generate slow square waves, this block reads them back and reports edges per window.
- Sits between a board input pin or an internal divided clock and the display/LED logic.
- Fully synchronous to clk. No derived clocks.

Parameters:
- GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz). Minimum 4.
- GATE_W, 27, width of the gate counter. Must satisfy 2^GATE_W >= GATE_CYCLES.
- RES_W, 16, width of the edge counter and result.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  measurement enable. Sampled every clk.
- sig_in  in  1  signal under measurement. Asynchronous to clk.
- freq_count  out  RES_W  rising edges counted in the last completed window.
- freq_valid  out  1  one-cycle pulse when freq_count/overflow update.
- overflow  out  1  last completed window saturated the edge counter.
- busy  out  1  high while a window is in progress.

Behaviour:
- Reset, asynchronous:
  - freq_count=0, freq_valid=0, overflow=0, busy=0.
  - Synchronizer flops, edge register, gate counter and edge counter all cleared.
  - FSM goes to IDLE.
- Input path:
  - sig_in passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - edge = s2 & ~s3.
  - A sig_in rise sampled at clk edge k produces edge=1 during cycle k+2.
  - sig_in pulses shorter than one clk period may be missed. This is acceptable.
- FSM states are IDLE and MEASURE.
- IDLE:
  - busy=0. Gate and edge counters held at 0.
  - en=1 moves to MEASURE on the next edge, with gate_cnt=0 and edge_cnt=0.
- MEASURE:
  - busy=1. gate_cnt increments each cycle.
  - If edge=1, edge_cnt increments, saturating at 2^RES_W-1. sat_flag is set if an increment is attempted while already at max.
- Window end (gate_cnt==GATE_CYCLES-1):
  - freq_count is set to the final edge_cnt. This includes an edge in that same cycle, with the same saturation rule applied.
  - overflow is set to the final sat_flag.
  - freq_valid pulses for exactly the next cycle.
  - gate_cnt, edge_cnt and sat_flag clear. If en=1 the block stays in MEASURE, back-to-back with no dead cycle.
- Window accounting:
  - Every edge pulse falls in exactly one window. Adjacent windows neither lose nor double-count edges.
  - The window length is exactly GATE_CYCLES cycles.
- en deasserted mid-window:
  - The window is aborted and the FSM returns to IDLE.
  - No freq_valid. freq_count and overflow hold their previous values.
  - Counters clear.
- en deasserted on the window-end cycle: the result is still published, then the FSM goes to IDLE.
- Reset mid-window: everything returns to reset values immediately and no stale result is published.
- Outputs hold between updates. freq_valid is never high for two consecutive cycles.
- Latency: a result is available one cycle after window end. An edge is counted 3 cycles after the sig_in rise.

Test Plan (sim with GATE_CYCLES=20, RES_W=4 unless noted):
- Reset/idle:
  - Stimulus: rst pulse mid-operation, then en=0 for 50 cycles with sig_in toggling.
  - Required: all outputs 0, no freq_valid, busy=0.
- Nominal:
  - Stimulus: en=1; sig_in square wave, period 4 clk (rise every 4 cycles), steady.
  - Required: freq_valid every 20 cycles, freq_count=5, overflow=0. busy stays 1 continuously between windows.
- Saturation:
  - Stimulus: sig_in period 2 clk (10 rises per window), RES_W=3.
  - Required: freq_count=7, overflow=1. Back to period 4: next result 5, overflow=0.
- Abort:
  - Stimulus: en=1, drop en at gate_cnt=10, re-raise 5 cycles later.
  - Required: no freq_valid for the aborted window; freq_count holds the prior value. The first new result arrives 20 cycles after re-enable with the correct count.
- Boundary edge:
  - Stimulus: align an edge pulse to the last window cycle, then to the first.
  - Required: counted once, in the window it falls in. The sum over two consecutive windows equals the total rises.
- Slow signal:
  - Stimulus: sig_in period 40 clk.
  - Required: results alternate between 0 and 1. The total over 4 windows is 2.
